// File: rtl/mem_ctrl.sv
// Memory-access stage: ALU and HI/LO results pass through, and MIPS loads/stores run over a req/ack bus.
// Define MEM_ALIGN_CHECK_EN to trap misaligned half/word accesses on addr_err_o instead of issuing them.
//
// state | meaning
// IDLE  | pass-through; a memory op raises stallreq and launches a request
// BUSY  | dbus_req held, waiting for dbus_ack or the ack timeout
// DONE  | load data and error flags presented for one cycle, stall released
module mem_ctrl #(
  parameter int ACK_TIMEOUT = 16,
  parameter int OP_W        = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] mem_op_i,
  input  logic [31:0]     mem_addr_i,
  input  logic [31:0]     mem_wdata_i,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [31:0]     result_i,
  input  logic            whilo_i,
  input  logic [31:0]     hi_i,
  input  logic [31:0]     lo_i,
  input  logic            dbus_ack,
  input  logic [31:0]     dbus_rdata,
  output logic            we_o,
  output logic [4:0]      waddr_o,
  output logic [31:0]     result_o,
  output logic            whilo_o,
  output logic [31:0]     hi_o,
  output logic [31:0]     lo_o,
  output logic            dbus_req,
  output logic            dbus_we,
  output logic [31:0]     dbus_addr,
  output logic [3:0]      dbus_sel,
  output logic [31:0]     dbus_wdata,
  output logic            stallreq,
  output logic            bus_err_o,
  output logic            addr_err_o
);

  localparam int CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  localparam logic [OP_W-1:0] OP_LB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LBU = OP_W'(2);
  localparam logic [OP_W-1:0] OP_LH  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_LHU = OP_W'(4);
  localparam logic [OP_W-1:0] OP_LW  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SB  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SH  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_SW  = OP_W'(8);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             abort_q, abort_d;
  logic             misal_q, misal_d;
  logic             req_q, req_d;

  logic        is_load, is_store, is_mem;
  logic        is_byte, is_half, is_word, is_signed;
  logic        misal;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [3:0]  st_sel;
  logic [31:0] st_wdata;

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_byte   = 1'b0;
    is_half   = 1'b0;
    is_word   = 1'b0;
    is_signed = 1'b0;
    case (mem_op_i)
      OP_LB:   begin is_load  = 1'b1; is_byte = 1'b1; is_signed = 1'b1; end
      OP_LBU:  begin is_load  = 1'b1; is_byte = 1'b1; end
      OP_LH:   begin is_load  = 1'b1; is_half = 1'b1; is_signed = 1'b1; end
      OP_LHU:  begin is_load  = 1'b1; is_half = 1'b1; end
      OP_LW:   begin is_load  = 1'b1; is_word = 1'b1; end
      OP_SB:   begin is_store = 1'b1; is_byte = 1'b1; end
      OP_SH:   begin is_store = 1'b1; is_half = 1'b1; end
      OP_SW:   begin is_store = 1'b1; is_word = 1'b1; end
      default: ;
    endcase
    is_mem = is_load | is_store;
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign misal = (is_half & mem_addr_i[0]) | (is_word & (mem_addr_i[1:0] != 2'b00));
`else
  assign misal = 1'b0;
`endif

  // Big-endian lanes: byte 0 lives in bits [31:24].
  always_comb begin
    case (mem_addr_i[1:0])
      2'b00:   ld_byte = rdata_q[31:24];
      2'b01:   ld_byte = rdata_q[23:16];
      2'b10:   ld_byte = rdata_q[15:8];
      default: ld_byte = rdata_q[7:0];
    endcase
    ld_half = mem_addr_i[1] ? rdata_q[15:0] : rdata_q[31:16];
    if (is_byte) begin
      ld_data = is_signed ? {{24{ld_byte[7]}}, ld_byte} : {24'd0, ld_byte};
    end else if (is_half) begin
      ld_data = is_signed ? {{16{ld_half[15]}}, ld_half} : {16'd0, ld_half};
    end else begin
      ld_data = rdata_q;
    end
  end

  always_comb begin
    st_sel   = 4'b1111;
    st_wdata = mem_wdata_i;
    if (is_store && is_byte) begin
      st_wdata = {4{mem_wdata_i[7:0]}};
      case (mem_addr_i[1:0])
        2'b00:   st_sel = 4'b1000;
        2'b01:   st_sel = 4'b0100;
        2'b10:   st_sel = 4'b0010;
        default: st_sel = 4'b0001;
      endcase
    end else if (is_store && is_half) begin
      st_wdata = {2{mem_wdata_i[15:0]}};
      st_sel   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      abort_q <= 1'b0;
      misal_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      abort_q <= abort_d;
      misal_q <= misal_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    abort_d = abort_q;
    misal_d = misal_q;
    req_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        abort_d = 1'b0;
        misal_d = 1'b0;
        if (is_mem) begin
          if (misal) begin
            state_d = S_DONE;
            misal_d = 1'b1;
          end else begin
            state_d = S_BUSY;
            req_d   = 1'b1;
          end
        end
      end
      S_BUSY: begin
        // An ack on the final allowed cycle still wins over the timeout.
        if (dbus_ack) begin
          rdata_d = dbus_rdata;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          abort_d = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          req_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    we_o       = we_i;
    waddr_o    = waddr_i;
    result_o   = result_i;
    whilo_o    = whilo_i;
    hi_o       = hi_i;
    lo_o       = lo_i;
    dbus_req   = req_q;
    dbus_we    = 1'b0;
    dbus_addr  = '0;
    dbus_sel   = '0;
    dbus_wdata = '0;
    stallreq   = 1'b0;
    bus_err_o  = 1'b0;
    addr_err_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_mem) begin
          stallreq = 1'b1;
          we_o     = 1'b0;
        end
      end
      S_BUSY: begin
        stallreq   = 1'b1;
        we_o       = 1'b0;
        dbus_we    = is_store;
        dbus_addr  = {mem_addr_i[31:2], 2'b00};
        dbus_sel   = st_sel;
        dbus_wdata = is_store ? st_wdata : 32'd0;
      end
      S_DONE: begin
        if (is_load) begin
          result_o = ld_data;
          we_o     = we_i & ~abort_q & ~misal_q;
        end else if (is_store) begin
          we_o = 1'b0;
        end
        bus_err_o = abort_q;
`ifdef MEM_ALIGN_CHECK_EN
        addr_err_o = misal_q;
`endif
      end
      default: ;
    endcase
    // Outputs are forced quiet while reset is held, including the pass-through paths.
    if (!rst) begin
      we_o       = 1'b0;
      waddr_o    = '0;
      result_o   = '0;
      whilo_o    = 1'b0;
      hi_o       = '0;
      lo_o       = '0;
      dbus_req   = 1'b0;
      dbus_we    = 1'b0;
      dbus_addr  = '0;
      dbus_sel   = '0;
      dbus_wdata = '0;
      stallreq   = 1'b0;
      bus_err_o  = 1'b0;
      addr_err_o = 1'b0;
    end
  end

endmodule
